// File: rtl/seg595_arbiter_pkg.sv
// Shared types for the 74HC595 frame arbiter: FSM state encoding and default frame width.
package seg595_arbiter_pkg;

  localparam int FRAME_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LATCH    = 3'd3,
    DONE     = 3'd4
  } seg_state_t;

endpackage

// File: rtl/seg595_rr_arb.sv
// Two-way request arbiter: round-robin when SEG595_RR_EN is defined, else fixed priority (req[0] wins).
// ptr is the index of the requester granted last.
module seg595_rr_arb (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

`ifdef SEG595_RR_EN
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr ? 2'b01 : 2'b10;
  end
`else
  logic unused_ptr;
  assign unused_ptr = ptr;

  always_comb begin
    grant = 2'b00;
    if (req[0])      grant = 2'b01;
    else if (req[1]) grant = 2'b10;
  end
`endif

endmodule

// File: rtl/seg595_arbiter.sv
// Arbitrates two frame requesters onto one 74HC595 chain: serialises FRAME_W bits MSB first,
// then pulses the latch clock. Define SEG595_RR_EN for round-robin arbitration.
module seg595_arbiter
  import seg595_arbiter_pkg::*;
#(
  parameter int CLK_DIV = 6,
  parameter int FRAME_W = FRAME_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [FRAME_W-1:0] data0,
  input  logic [FRAME_W-1:0] data1,
  output logic [1:0]         ack,
  output logic               busy,
  output logic               seg_sck,
  output logic               seg_din,
  output logic               seg_rck
);

  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(FRAME_W + 1);
  localparam logic [HW-1:0] HLAST = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLAST = BW'(FRAME_W - 1);

  seg_state_t         state, state_nxt;
  logic [HW-1:0]      hcnt;
  logic [BW-1:0]      bcnt;
  logic [FRAME_W-1:0] sreg;
  logic               win;
  logic               rr_ptr;
  logic [1:0]         grant;
  logic               hlast;

  assign hlast = (hcnt == HLAST);

  seg595_rr_arb u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req != 2'b00) state_nxt = SHIFT_LO;
      SHIFT_LO: if (hlast)        state_nxt = SHIFT_HI;
      SHIFT_HI: if (hlast)        state_nxt = (bcnt == BLAST) ? LATCH : SHIFT_LO;
      LATCH:    if (hlast)        state_nxt = DONE;
      DONE:                       state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Datapath: data and winner are captured only on the grant edge, so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt   <= '0;
      bcnt   <= '0;
      sreg   <= '0;
      win    <= 1'b0;
      rr_ptr <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          hcnt <= '0;
          bcnt <= '0;
          if (grant != 2'b00) begin
            sreg   <= grant[1] ? data1 : data0;
            win    <= grant[1];
            rr_ptr <= grant[1];
          end
        end
        SHIFT_LO, LATCH: hcnt <= hlast ? '0 : hcnt + HW'(1);
        SHIFT_HI: begin
          if (hlast) begin
            hcnt <= '0;
            bcnt <= bcnt + BW'(1);
            sreg <= {sreg[FRAME_W-2:0], 1'b0};
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        default: hcnt <= '0;
      endcase
    end
  end

  // Outputs are forced low while rst is held, even before the aborting edge.
  always_comb begin
    ack     = 2'b00;
    busy    = 1'b0;
    seg_sck = 1'b0;
    seg_din = 1'b0;
    seg_rck = 1'b0;
    if (!rst) begin
      case (state)
        SHIFT_LO: begin
          busy    = 1'b1;
          seg_din = sreg[FRAME_W-1];
        end
        SHIFT_HI: begin
          busy    = 1'b1;
          seg_sck = 1'b1;
          seg_din = sreg[FRAME_W-1];
        end
        LATCH: begin
          busy    = 1'b1;
          seg_rck = 1'b1;
        end
        DONE: begin
          busy = 1'b1;
          ack  = win ? 2'b10 : 2'b01;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seg595_arbiter.md
SEG595_ARBITER -- requirements
Module: seg595_arbiter

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 6, giving the clk cycles per SCK half-period (6 gives 1 MHz SCK at 12 MHz clk; legal range 1..255).
REQ-002 The block SHALL have parameter FRAME_W, default 16, giving the bits per frame (8 segment bits followed by 8 digit-select bits).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 2 bits: per-requester frame request, level-held.
REQ-006 The block SHALL have port data0, input, FRAME_W bits: requester 0 frame data.
REQ-007 The block SHALL have port data1, input, FRAME_W bits: requester 1 frame data.
REQ-008 The block SHALL have port ack, output, 2 bits: one-cycle pulse, one-hot, marking the granted frame as latched.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a frame is in flight.
REQ-010 The block SHALL have ports seg_sck, seg_din and seg_rck, outputs, 1 bit each: 74HC595 shift clock, serial data and latch clock.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, SHIFT_LO, SHIFT_HI, LATCH and DONE.
REQ-012 In IDLE with req != 0, the next edge SHALL capture the winner's data into the shift register, record the winner, set busy=1 and enter SHIFT_LO.
REQ-013 SHIFT_LO SHALL hold seg_sck=0 for CLK_DIV cycles with seg_din = current MSB.
REQ-014 SHIFT_HI SHALL hold seg_sck=1 for CLK_DIV cycles, with seg_din stable.
REQ-015 On leaving SHIFT_HI, the register SHALL shift left one bit.
REQ-016 After FRAME_W bit periods the FSM SHALL enter LATCH; otherwise it SHALL return to SHIFT_LO.
REQ-017 LATCH SHALL hold seg_rck=1 and seg_sck=0 for CLK_DIV cycles.
REQ-018 DONE SHALL last one cycle, pulse ack[winner]=1, drop busy and return to IDLE.
REQ-019 Busy duration SHALL be exactly (2*FRAME_W+1)*CLK_DIV+1 cycles, which is 199 cycles at the defaults.
REQ-020 Frame data SHALL be sampled only at grant; changes to data0/data1 or req during a frame SHALL be ignored.
REQ-021 Deassertion of req mid-frame SHALL NOT abort the frame, and the ack SHALL still be issued.
REQ-022 A request still asserted in IDLE after DONE SHALL be re-arbitrated, with no idle gap beyond the DONE cycle.
REQ-023 The half-period counter SHALL be ceil(log2(CLK_DIV+1)) bits, the bit counter ceil(log2(FRAME_W+1)) bits, and neither counter SHALL wrap within a frame.
REQ-024 seg_sck and seg_rck SHALL never be high in the same cycle.

Reset
REQ-025 While rst=1, every output SHALL be 0 and the FSM SHALL be in IDLE.
REQ-026 The round-robin pointer SHALL reset to favour requester 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame on the same edge with no ack and no rck pulse, and the first post-reset frame SHALL restart from bit 0.

Configuration
REQ-028 With SEG595_RR_EN defined, arbitration SHALL be round-robin: on simultaneous requests the grant goes to the requester not granted last, and the pointer updates at grant.
REQ-029 Without SEG595_RR_EN, arbitration SHALL be fixed priority with requester 0 always winning simultaneous requests.
REQ-030 Single-request behaviour SHALL be identical in both configurations.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding and the FRAME_W default constant.
REQ-032 One sub-module, seg595_rr_arb, SHALL implement the 2-way arbiter (req, pointer -> one-hot grant), with a compile-time mux on SEG595_RR_EN; serializer and FSM logic SHALL stay in seg595_arbiter.

Verification
REQ-033 Reset, then req=2'b01 with data0=16'hA5C3 held: busy asserts next cycle; 16 SCK rises sample din 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; one rck pulse of 6 cycles; ack=2'b01 after 199 busy cycles.
REQ-034 req=2'b11 continuously with SEG595_RR_EN defined: acks alternate 01,10,01,10; without the macro, acks are 01 every frame.
REQ-035 Grant data1=16'h00FF, then change data1 to 16'hFFFF and drop req[1] at bit 5: shifted pattern is still 16'h00FF and ack=2'b10 is issued.
REQ-036 Assert rst at bit 9 of a frame: next cycle sck=din=rck=busy=0, no ack; after release, req=2'b01 with data0=16'h8001 gives a full clean frame.
REQ-037 CLK_DIV=1, FRAME_W=16: busy for 34 cycles, alternate-cycle SCK, and seg_sck and seg_rck never both high across the whole test.
